// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux_scan_ctrl board controller:
// FSM state encoding, button indices, LED field offsets and the select-step helper.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        SCAN   = 2'd1,
        HOLD   = 2'd2
    } state_e;

    localparam int BTN_MODE = 0;
    localparam int BTN_HOLD = 1;
    localparam int BTN_STEP = 2;
    localparam int BTN_DIR  = 3;
    localparam int BTN_CLR  = 4;
    localparam int NUM_BTN  = 5;

    localparam int LED_DATA   = 0;
    localparam int LED_SEL    = 1;
    localparam int LED_ST     = 3;
    localparam int LED_DIR    = 5;
    localparam int LED_ONEHOT = 6;
    localparam int LED_ADV    = 10;

    // Two-bit arithmetic gives the 3->0 and 0->3 wrap for free.
    function automatic logic [1:0] step_sel(input logic [1:0] sel, input logic dir);
        return dir ? (sel - 2'd1) : (sel + 2'd1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push button: 2-flop synchronizer, optional debouncer (MUX_SCAN_DEBOUNCE_EN)
// and a rising-edge detector producing a one-cycle press pulse.
module btn_debounce
    import mux_scan_pkg::*;
#(
    parameter int DB_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic sync1_q;
    logic sync2_q;
    logic lvlPrev_q;
    logic lvl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            lvlPrev_q <= 1'b0;
        end else begin
            sync1_q   <= btn;
            sync2_q   <= sync1_q;
            lvlPrev_q <= lvl;
        end
    end

`ifdef MUX_SCAN_DEBOUNCE_EN
    localparam int CntW = $clog2(DB_CYCLES);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            lvl_q;
    logic            lvl_d;

    // The accepted level only flips after DB_CYCLES consecutive disagreeing samples.
    always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        if (sync2_q != lvl_q) begin
            if (cnt_q == CntW'(DB_CYCLES - 1)) begin
                lvl_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
        end
    end

    assign lvl = lvl_q;
`else
    localparam int unusedDbCycles = DB_CYCLES;

    assign lvl = sync2_q;
`endif

    assign press = lvl & ~lvlPrev_q;

endmodule

// File: rtl/mux_scan_ctrl.sv
// 4:1 selector controller with manual / round-robin scan / hold policies and
// registered LED status. Define MUX_SCAN_DEBOUNCE_EN to debounce the buttons.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL_CYCLES = 5000000,
    parameter int DB_CYCLES    = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  btn,
    input  logic [7:0]  sw,
    output logic [15:0] ledr
);

    localparam int DwW = $clog2(DWELL_CYCLES);

    logic [NUM_BTN-1:0] press;

    state_e         st_q, st_d;
    logic [1:0]     sel_q, sel_d;
    logic           dir_q, dir_d;
    logic [DwW-1:0] dwell_q, dwell_d;
    logic           adv_q, adv_d;
    logic [15:0]    ledr_q, ledr_d;

    logic [3:0] data;
    logic       unusedSw;

    assign data     = sw[3:0];
    assign unusedSw = ^sw[7:6];

    for (genvar i = 0; i < NUM_BTN; i++) begin : gBtn
        btn_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) uDebounce (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn[i]),
            .press(press[i])
        );
    end

    // Only the highest-priority effective press acts; a press also pre-empts
    // the dwell expiry for that cycle, so dwell simply holds unless cleared.
    always_comb begin
        st_d    = st_q;
        sel_d   = sel_q;
        dir_d   = dir_q;
        dwell_d = dwell_q;
        adv_d   = 1'b0;

        if (press[BTN_CLR]) begin
            st_d    = MANUAL;
            dir_d   = 1'b0;
            dwell_d = '0;
        end else if (press[BTN_MODE]) begin
            st_d    = (st_q == MANUAL) ? SCAN : MANUAL;
            dwell_d = '0;
        end else if (press[BTN_HOLD] && (st_q != MANUAL)) begin
            st_d = (st_q == SCAN) ? HOLD : SCAN;
        end else if (press[BTN_STEP] && (st_q != MANUAL)) begin
            sel_d   = step_sel(sel_q, dir_q);
            dwell_d = '0;
        end else if (press[BTN_DIR]) begin
            dir_d = ~dir_q;
        end else begin
            case (st_q)
                MANUAL: begin
                    sel_d   = sw[5:4];
                    dwell_d = '0;
                end
                SCAN: begin
                    if (dwell_q == DwW'(DWELL_CYCLES - 1)) begin
                        dwell_d = '0;
                        sel_d   = step_sel(sel_q, dir_q);
                        adv_d   = 1'b1;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
                HOLD: begin
                end
                default: begin
                    st_d    = MANUAL;
                    dwell_d = '0;
                end
            endcase
        end
    end

    // The data bit tracks the upcoming select; the other fields show current state.
    always_comb begin
        ledr_d                     = '0;
        ledr_d[LED_DATA]           = data[sel_d];
        ledr_d[LED_SEL +: 2]       = sel_q;
        ledr_d[LED_ST +: 2]        = st_q;
        ledr_d[LED_DIR]            = dir_q;
        ledr_d[LED_ONEHOT +: 4]    = 4'b0001 << sel_q;
        ledr_d[LED_ADV]            = adv_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= MANUAL;
            sel_q   <= 2'd0;
            dir_q   <= 1'b0;
            dwell_q <= '0;
            adv_q   <= 1'b0;
            ledr_q  <= 16'h0000;
        end else begin
            st_q    <= st_d;
            sel_q   <= sel_d;
            dir_q   <= dir_d;
            dwell_q <= dwell_d;
            adv_q   <= adv_d;
            ledr_q  <= ledr_d;
        end
    end

    assign ledr = ledr_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: directed scenario steps with randomized
// data, every cycle compared against a behavioural model of the controller.
`timescale 1ns/1ps
module tb_mux_scan_ctrl;

    localparam int DW = 8;
    localparam int DB = 4;
`ifdef MUX_SCAN_DEBOUNCE_EN
    localparam int LAT   = DB + 4;
    localparam bit DB_EN = 1'b1;
`else
    localparam int LAT   = 4;
    localparam bit DB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  btn;
    logic [7:0]  sw;
    logic [15:0] ledr;

    int nCmp  = 0;
    int nFail = 0;
    int cyc   = 0;

    int mSt, mSel, mDir, mDwell;
    bit mAdvQ;
    logic [4:0] mS1, mS2, mLvl, mPrev;
    int mCnt [5];
    logic [15:0] expLedr;

    int advQ [$];
    int advT [$];

    mux_scan_ctrl #(
        .DWELL_CYCLES(DW),
        .DB_CYCLES   (DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .btn (btn),
        .sw  (sw),
        .ledr(ledr)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        mSt = 0; mSel = 0; mDir = 0; mDwell = 0; mAdvQ = 0;
        mS1 = '0; mS2 = '0; mLvl = '0; mPrev = '0;
        for (int i = 0; i < 5; i++) mCnt[i] = 0;
        expLedr = '0;
    endtask

    // Model of one clock edge, evaluated on the inputs present before the edge.
    task automatic modelEdge();
        logic [4:0] lvlNow, prs;
        int act, nSt, nSel, nDir, nDwell;
        bit adv;
        lvlNow = DB_EN ? mLvl : mS2;
        prs    = lvlNow & ~mPrev;
        act = -1;
        if (prs[4]) act = 4;
        else if (prs[0]) act = 0;
        else if (prs[1] && mSt != 0) act = 1;
        else if (prs[2] && mSt != 0) act = 2;
        else if (prs[3]) act = 3;
        nSt = mSt; nSel = mSel; nDir = mDir; nDwell = mDwell; adv = 0;
        case (act)
            4: begin nSt = 0; nDir = 0; nDwell = 0; end
            0: begin nSt = (mSt == 0) ? 1 : 0; nDwell = 0; end
            1: nSt = (mSt == 1) ? 2 : 1;
            2: begin nSel = (mSel + (mDir ? 3 : 1)) % 4; nDwell = 0; end
            3: nDir = 1 - mDir;
            default: begin
                if (mSt == 0) begin
                    nSel = int'(sw[5:4]);
                    nDwell = 0;
                end else if (mSt == 1) begin
                    if (mDwell == DW - 1) begin
                        nDwell = 0;
                        nSel = (mSel + (mDir ? 3 : 1)) % 4;
                        adv = 1;
                    end else begin
                        nDwell = mDwell + 1;
                    end
                end
            end
        endcase
        expLedr = 16'(((int'(sw) >> nSel) & 1) | (mSel << 1) | (mSt << 3) | (mDir << 5)
                      | ((1 << mSel) << 6) | (int'(mAdvQ) << 10));
        for (int i = 0; i < 5; i++) begin
            if (DB_EN) begin
                if (mLvl[i] != mS2[i]) begin
                    if (mCnt[i] == DB - 1) begin
                        mLvl[i] = mS2[i];
                        mCnt[i] = 0;
                    end else begin
                        mCnt[i]++;
                    end
                end else begin
                    mCnt[i] = 0;
                end
            end
        end
        mPrev = lvlNow;
        mS2 = mS1;
        mS1 = btn;
        mSt = nSt; mSel = nSel; mDir = nDir; mDwell = nDwell; mAdvQ = adv;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s @cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] b, input logic [7:0] s, input int n, input bit rndData);
        for (int k = 0; k < n; k++) begin
            btn = b;
            sw  = rndData ? {s[7:4], 4'($urandom)} : s;
            modelEdge();
            @(posedge clk);
            @(negedge clk);
            cyc++;
            checkOutput("ledr", ledr, expLedr);
            if (ledr[10]) begin
                advQ.push_back(int'(ledr[2:1]));
                advT.push_back(cyc);
            end
        end
    endtask

    initial begin
        int lat;
        int selBefore;
        int expSeq [4];
        expSeq = '{1, 2, 3, 0};

        rst = 1'b1; btn = '0; sw = '0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        checkOutput("resetLedr", ledr, 16'h0000);
        rst = 1'b0;
        checkOutput("releaseLedr", ledr, 16'h0000);

        // Manual selection follows sw[5:4] after two edges.
        applyStimulus(5'b0, 8'b0010_1010, 2, 0);
        checkOutput("manualSel", {14'b0, ledr[2:1]}, 16'd2);
        checkOutput("manualOneHot", {15'b0, ledr[8]}, 16'd1);
        for (int k = 0; k < 8; k++) applyStimulus(5'b0, 8'($urandom), 1, 0);

        // Enter SCAN from sel 0, measure latency and the advance sequence.
        applyStimulus(5'b0, 8'h0A, 3, 0);
        advQ.delete(); advT.delete();
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(5'b00001, 8'h0A, 1, 1);
            if (lat < 0 && ledr[4:3] == 2'd1) lat = k;
        end
        checkOutput("modeLatency", 16'(lat), 16'(LAT));
        applyStimulus(5'b0, 8'h0A, 40, 1);
        checkOutput("advCount", {15'b0, advQ.size() >= 4}, 16'd1);
        for (int i = 0; i < 4; i++)
            checkOutput("scanSeq", (advQ.size() > i) ? 16'(advQ[i]) : 16'hFFFF, 16'(expSeq[i]));
        checkOutput("dwellSpacing", (advT.size() > 1) ? 16'(advT[1] - advT[0]) : 16'hFFFF, 16'(DW));

        // Reverse direction while scanning.
        applyStimulus(5'b01000, 8'h0A, 6, 1);
        applyStimulus(5'b0, 8'h0A, 2 * DW + 4, 1);
        checkOutput("dirDown", {15'b0, ledr[5]}, 16'd1);

        // HOLD freezes sel; a step moves it exactly once.
        applyStimulus(5'b00010, 8'h0A, 6, 1);
        applyStimulus(5'b0, 8'h0A, 4, 1);
        advQ.delete();
        applyStimulus(5'b0, 8'h0A, 30, 1);
        checkOutput("holdSt", {14'b0, ledr[4:3]}, 16'd2);
        checkOutput("holdFrozen", 16'(advQ.size()), 16'd0);
        selBefore = mSel;
        applyStimulus(5'b00100, 8'h0A, 6, 1);
        applyStimulus(5'b0, 8'h0A, 24, 1);
        checkOutput("holdStep", {14'b0, ledr[2:1]}, 16'((selBefore + 3) % 4));
        checkOutput("holdStepOnce", 16'(advQ.size()), 16'd0);

        // Clear beats mode when pressed together.
        applyStimulus(5'b10001, 8'h0A, 6, 1);
        applyStimulus(5'b0, 8'h0A, 10, 1);
        checkOutput("clrSt", {14'b0, ledr[4:3]}, 16'd0);
        checkOutput("clrDir", {15'b0, ledr[5]}, 16'd0);
        applyStimulus(5'b00001, 8'h0A, 2, 1);
        applyStimulus(5'b0, 8'h0A, 12, 1);
`ifdef MUX_SCAN_DEBOUNCE_EN
        checkOutput("bounceIgnored", {14'b0, ledr[4:3]}, 16'd0);
`endif

        // Asynchronous reset in the middle of a scan.
        if (mSt != 1) begin
            applyStimulus(5'b00001, 8'h0A, 6, 1);
            applyStimulus(5'b0, 8'h0A, 6, 1);
        end
        applyStimulus(5'b0, 8'h0A, 12, 1);
        btn = '0;
        #2 rst = 1'b1;
        #1 checkOutput("asyncReset", ledr, 16'h0000);
        modelReset();
        @(negedge clk);
        checkOutput("resetHeld", ledr, 16'h0000);
        rst = 1'b0;
        applyStimulus(5'b0, 8'b0011_0101, 2, 0);
        checkOutput("manualAfterReset", {14'b0, ledr[2:1]}, 16'd3);

        for (int k = 0; k < 40; k++) begin
            logic [4:0] b;
            b = ($urandom_range(2) == 0) ? 5'(1 << $urandom_range(4)) : 5'b0;
            applyStimulus(b, 8'($urandom), 6, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
